lightsout_scan_sched: RTL and testbench
=======================================

// Module: lightsout_scan_sched
// PURPOSE
//  Time-multiplexes the shared 3x3 row/column matrix between LED drive and button sense.
//  Per column, the sequence is: drive LEDs, blank the rows, then sample the buttons.
//  Debounces each key across scans and delivers one press event per key press to the game core.
//  Events go through a valid/ready queue. Sits between the board pins and the game-state core.
// PARAMETERS
//  N_COLS          3   matrix columns
//  N_ROWS          3   matrix rows
//  DWELL_CYCLES    64  LED on-time per column (>=1)
//  BLANK_CYCLES    4   rows forced low before sampling, column still active (>=1)
//  DEBOUNCE_SCANS  16  consecutive pressed samples required for an event (>=1)
//  QDEPTH          4   event queue depth (power of 2, >=2)
// PORTS
//  CLK        in   1                clock
//  RESET_N    in   1                synchronous reset, active-low
//  LEDS_IN    in   N_ROWS*N_COLS    LED state from game core; index = row*N_COLS+col
//  ROW_SENSE  in   N_ROWS           button row inputs, active-high
//  COL_OUT    out  N_COLS           one-hot column strobe
//  ROW_OUT    out  N_ROWS           LED row drive
//  EVT_VALID  out  1                queue head valid
//  EVT_READY  in   1                consumer accepts head when EVT_VALID&&EVT_READY
//  EVT_KEY    out  4                key index of queue head (row*N_COLS+col)
//  SCAN_TICK  out  1                1-cycle pulse at end of each full matrix scan
//  DROP       out  1                sticky: an event was lost to a full queue
// BEHAVIOUR
//  - Reset (RESET_N=0 at posedge): state DRIVE, col=0, phase counter=0, all debounce counters=0.
//    Queue is emptied, DROP=0, SCAN_TICK=0, EVT_VALID=0. COL_OUT=...001 on the first cycle after reset.
//    A reset mid-scan or mid-queue discards everything; no event survives reset.
//  - FSM per column: DRIVE (DWELL_CYCLES) -> BLANK (BLANK_CYCLES) -> SAMPLE (N_ROWS cycles, row r in cycle r).
//    After SAMPLE, move to DRIVE of col+1. Wrap to col 0 after col N_COLS-1.
//    Column period = DWELL+BLANK+N_ROWS. Scan period = N_COLS*column period.
//  - COL_OUT is one-hot on the current col in all three states, and never all-zero after reset.
//  - ROW_OUT[r] = LEDS_IN[r*N_COLS+col] in DRIVE, and 0 in BLANK/SAMPLE. It is registered (changes with state).
//  - SAMPLE cycle for row r updates key k=r*N_COLS+col:
//    - ROW_SENSE[r]=1: cnt[k] <= min(cnt[k]+1, DEBOUNCE_SCANS); release: cnt[k] <= 0.
//    - Event fires only when cnt[k]==DEBOUNCE_SCANS-1 and ROW_SENSE[r]=1, so exactly one event per press.
//      A held key never repeats; a release plus DEBOUNCE_SCANS new presses gives a new event.
//  - At most one push per cycle, because rows are sampled on separate cycles. Event order is scan order.
//  - Queue: push appends k, pop occurs on EVT_VALID&&EVT_READY.
//    - EVT_VALID/EVT_KEY are registered; an event is visible 1 cycle after its SAMPLE cycle.
//    - Full and push without pop: event dropped, DROP<=1 (held until reset).
//    - Full with simultaneous pop and push: both happen, no drop.
//    - Empty and push: EVT_VALID=1 next cycle. Pop when empty: ignored.
//    - EVT_KEY is stable while EVT_VALID&&!EVT_READY.
//  - SCAN_TICK=1 in the cycle after the last SAMPLE cycle of col N_COLS-1.
//  - ROW_SENSE is sampled only in SAMPLE; its value in DRIVE/BLANK is ignored.
// STRUCTURE
//  - lightsout_pkg:
//    - scan_state_t enum {DRIVE, BLANK, SAMPLE}
//    - KEY_W=4 and key_idx(row,col) function
//    - default matrix dimensions
//  - Sub-module lightsout_evt_fifo: QDEPTH x 4-bit synchronous FIFO.
//    It has push/pop/full/empty and registered head. The scheduler keeps FSM, counters, debounce and DROP.
// TESTING (bench params: DWELL=4, BLANK=2, DEBOUNCE=3, QDEPTH=2; col period 9, scan 27)
//  1. Reset, then free-run with LEDS_IN=9'b101010101.
//     -> COL_OUT 001,010,100 each for 9 cycles.
//     -> ROW_OUT=LEDS_IN column bits for 4 cycles, then 0 for 5 cycles.
//     -> SCAN_TICK every 27 cycles; EVT_VALID=0, DROP=0.
//  2. ROW_SENSE[1]=1 only during col1 SAMPLE, for 10 scans.
//     -> exactly one event, EVT_KEY=4, valid 1 cycle after the 3rd scan's row-1 SAMPLE.
//  3. Key 0 pressed 2 scans, released 1 scan, pressed 3 scans.
//     -> single EVT_KEY=0, only after the final 3rd pressed scan.
//  4. Keys 0 and 6 both held (col0, rows 0 and 2), EVT_READY=1.
//     -> events 0 then 6, two cycles apart, same scan.
//  5. EVT_READY=0, keys 0,1,2 qualify in the same scan.
//     -> queue holds 0,1; DROP=1. With EVT_READY=1 after that, pops 0 then 1, then EVT_VALID=0; DROP stays 1.
//  6. Queue holding 2 events, cnt[4]=2, assert RESET_N=0 during BLANK of col1.
//     -> next cycle EVT_VALID=0, DROP=0, COL_OUT=001, state DRIVE.
//     -> key 4 then needs 3 fresh scans to fire.

Source files
------------

// File: rtl/lightsout_pkg.sv
// Shared types and helpers for the lights-out matrix scanner.
// Holds the scan state encoding, key index width and default matrix size.
package lightsout_pkg;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        BLANK  = 2'd1,
        SAMPLE = 2'd2
    } scan_state_t;

    localparam int KEY_W      = 4;
    localparam int N_COLS_DEF = 3;
    localparam int N_ROWS_DEF = 3;

    function automatic logic [KEY_W-1:0] key_idx(
        input int unsigned row,
        input int unsigned col,
        input int unsigned n_cols
    );
        int unsigned k;
        k = row * n_cols + col;
        return k[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/lightsout_evt_fifo.sv
// Key-event FIFO: pushed data is visible at the head one cycle later; head is a read of stored flops.
// A pop on a full FIFO frees the slot for a same-cycle push; pop when empty is ignored.
module lightsout_evt_fifo
    import lightsout_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = KEY_W
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == FULL_CNT);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lightsout_scan_sched.sv
// Shares the row/column matrix between LED drive and debounced key sensing; events appear 1 cycle after sampling.
// Events queue behind EVT_VALID/EVT_READY; a push into a full queue with no pop is lost and sets sticky DROP.
module lightsout_scan_sched
    import lightsout_pkg::*;
#(
    parameter int N_COLS         = N_COLS_DEF,
    parameter int N_ROWS         = N_ROWS_DEF,
    parameter int DWELL_CYCLES   = 64,
    parameter int BLANK_CYCLES   = 4,
    parameter int DEBOUNCE_SCANS = 16,
    parameter int QDEPTH         = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [N_ROWS*N_COLS-1:0] LEDS_IN,
    input  logic [N_ROWS-1:0]        ROW_SENSE,
    output logic [N_COLS-1:0]        COL_OUT,
    output logic [N_ROWS-1:0]        ROW_OUT,
    output logic                     EVT_VALID,
    input  logic                     EVT_READY,
    output logic [KEY_W-1:0]         EVT_KEY,
    output logic                     SCAN_TICK,
    output logic                     DROP
);
    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int MAXP_A = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MAXP   = (MAXP_A > N_ROWS) ? MAXP_A : N_ROWS;
    localparam int PW     = $clog2(MAXP) + 1;
    localparam int CLW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int CW     = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [PW-1:0]  DWELL_LAST = PW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0]  BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0]  ROWS_LAST  = PW'(N_ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST   = CLW'(N_COLS - 1);
    localparam logic [CW-1:0]  CNT_MAX    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0]  CNT_FIRE   = CW'(DEBOUNCE_SCANS - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [PW-1:0]     r_phase;
    logic [PW-1:0]     w_phase_nxt;
    logic [CLW-1:0]    r_col;
    logic [CLW-1:0]    w_col_nxt;
    logic              w_scan_end;
    logic [CW-1:0]     r_cnt [N_KEYS];
    logic [N_ROWS-1:0] r_row_out;
    logic [N_ROWS-1:0] w_row_nxt;
    logic [N_ROWS-1:0] w_row_col0;
    logic              r_scan_tick;
    logic              r_drop;

    logic              w_sample;
    logic              w_sense;
    logic [KEY_W-1:0]  w_key;
    logic [CW-1:0]     w_cnt_cur;
    logic              w_fire;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 1'b1;
        w_col_nxt   = r_col;
        w_scan_end  = 1'b0;
        case (r_state)
            DRIVE: begin
                if (r_phase == DWELL_LAST) begin
                    w_state_nxt = BLANK;
                    w_phase_nxt = '0;
                end
            end
            BLANK: begin
                if (r_phase == BLANK_LAST) begin
                    w_state_nxt = SAMPLE;
                    w_phase_nxt = '0;
                end
            end
            SAMPLE: begin
                if (r_phase == ROWS_LAST) begin
                    w_state_nxt = DRIVE;
                    w_phase_nxt = '0;
                    if (r_col == COL_LAST) begin
                        w_col_nxt  = '0;
                        w_scan_end = 1'b1;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = DRIVE;
                w_phase_nxt = '0;
                w_col_nxt   = '0;
            end
        endcase
    end

    // In SAMPLE the phase counter doubles as the row being sensed.
    always_comb begin
        w_sample  = (r_state == SAMPLE);
        w_key     = key_idx(32'(r_phase), 32'(r_col), N_COLS);
        w_sense   = 1'b0;
        w_cnt_cur = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (r_phase == PW'(r)) begin
                w_sense = ROW_SENSE[r];
            end
        end
        for (int k = 0; k < N_KEYS; k++) begin
            if (w_key == KEY_W'(k)) begin
                w_cnt_cur = r_cnt[k];
            end
        end
        w_fire = w_sample && w_sense && (w_cnt_cur == CNT_FIRE);
    end

    // Row drive is precomputed for the upcoming state so it lines up with COL_OUT.
    always_comb begin
        w_row_nxt  = '0;
        w_row_col0 = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            w_row_col0[r] = LEDS_IN[r*N_COLS];
            for (int c = 0; c < N_COLS; c++) begin
                if (w_state_nxt == DRIVE && w_col_nxt == CLW'(c)) begin
                    w_row_nxt[r] = LEDS_IN[r*N_COLS+c];
                end
            end
        end
    end

    always_comb begin
        COL_OUT = '0;
        for (int c = 0; c < N_COLS; c++) begin
            if (r_col == CLW'(c)) begin
                COL_OUT[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= DRIVE;
            r_phase     <= '0;
            r_col       <= '0;
            r_row_out   <= w_row_col0;
            r_scan_tick <= 1'b0;
            r_drop      <= 1'b0;
            for (int k = 0; k < N_KEYS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_col       <= w_col_nxt;
            r_row_out   <= w_row_nxt;
            r_scan_tick <= w_scan_end;
            r_drop      <= r_drop | (w_fire && w_full && !w_pop);
            for (int k = 0; k < N_KEYS; k++) begin
                if (w_sample && w_key == KEY_W'(k)) begin
                    if (!w_sense) begin
                        r_cnt[k] <= '0;
                    end else if (r_cnt[k] != CNT_MAX) begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    assign w_pop = !w_empty && EVT_READY;

    lightsout_evt_fifo #(
        .DEPTH (QDEPTH),
        .W     (KEY_W)
    ) u_evt_fifo (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_push     (w_fire),
        .i_push_dat (w_key),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head_dat (EVT_KEY)
    );

    assign EVT_VALID = !w_empty;
    assign ROW_OUT   = r_row_out;
    assign SCAN_TICK = r_scan_tick;
    assign DROP      = r_drop;

endmodule

// File: tb/tb_lightsout_scan_sched.sv
// Randomized bench for lightsout_scan_sched: scan timing derived arithmetically from the cycle count,
// key presses debounced by a per-key streak model, events checked through an expected-event queue.
module tb_lightsout_scan_sched;
    localparam int NC = 3;
    localparam int NR = 3;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int DB = 3;
    localparam int QD = 2;
    localparam int CP = DW + BL + NR;
    localparam int SP = NC * CP;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [8:0] LEDS_IN = 9'b101010101;
    logic [2:0] ROW_SENSE = '0;
    logic [2:0] COL_OUT;
    logic [2:0] ROW_OUT;
    logic       EVT_VALID;
    logic       EVT_READY = 1'b0;
    logic [3:0] EVT_KEY;
    logic       SCAN_TICK;
    logic       DROP;

    always #5 CLK = ~CLK;

    lightsout_scan_sched #(
        .N_COLS         (NC),
        .N_ROWS         (NR),
        .DWELL_CYCLES   (DW),
        .BLANK_CYCLES   (BL),
        .DEBOUNCE_SCANS (DB),
        .QDEPTH         (QD)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .LEDS_IN   (LEDS_IN),
        .ROW_SENSE (ROW_SENSE),
        .COL_OUT   (COL_OUT),
        .ROW_OUT   (ROW_OUT),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_KEY   (EVT_KEY),
        .SCAN_TICK (SCAN_TICK),
        .DROP      (DROP)
    );

    typedef struct {
        int key;
        int vis;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_en  = 1'b0;
    bit   exp_drop = 1'b0;
    bit   drop_nx  = 1'b0;
    int   mq = 0;
    int   streak [9];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit bit_of9(input logic [8:0] v, input int i);
        logic [8:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        mq       = 0;
        drop_nx  = 1'b0;
        exp_drop = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 9; i++) streak[i] = 0;
    endfunction

    // Monitor: expected pins come from where cycle `cyc` falls in the scan.
    always @(negedge CLK) begin
        int pos;
        int col;
        int off;
        logic [2:0] ecol;
        logic [2:0] erow;
        logic etick;
        logic evld;
        if (chk_en) begin
            pos   = cyc % SP;
            col   = pos / CP;
            off   = pos % CP;
            ecol  = 3'(1 << col);
            erow  = '0;
            if (off < DW)
                for (int r = 0; r < NR; r++) erow[r] = bit_of9(LEDS_IN, r * NC + col);
            etick = (pos == 0) && (cyc > 0);
            check("scan_pins", 32'({COL_OUT, ROW_OUT, SCAN_TICK}), 32'({ecol, erow, etick}));
            evld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            check("evt_valid", 32'(EVT_VALID), 32'(evld));
            if (evld) begin
                check("evt_key", 32'(EVT_KEY), 32'(exp_q[0].key));
                if (EVT_READY) void'(exp_q.pop_front());
            end
            check("drop", 32'(DROP), 32'(exp_drop));
        end
    end

    task automatic step(input logic [8:0] press, input int rdy_mode, input bit do_rst);
        int pos;
        int col;
        int off;
        int row;
        int k;
        bit ev;
        bit pk;
        bit pop;
        logic [2:0] rs;
        pos = cyc % SP;
        col = pos / CP;
        off = pos % CP;
        exp_drop  = drop_nx;
        EVT_READY = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
        rs = 3'($urandom);
        ev = 1'b0;
        k  = 0;
        if (off >= DW + BL) begin
            row = off - DW - BL;
            k   = row * NC + col;
            pk  = bit_of9(press, k);
            rs  = (rs & ~(3'(1) << row)) | (3'(pk) << row);
            if (!do_rst) begin
                if (pk) begin
                    streak[k]++;
                    ev = (streak[k] == DB);
                end else begin
                    streak[k] = 0;
                end
            end
        end
        ROW_SENSE = rs;
        RESET_N   = !do_rst;
        if (!do_rst) begin
            pop = (mq > 0) && EVT_READY;
            if (ev) begin
                if (mq == QD && !pop) begin
                    drop_nx = 1'b1;
                end else begin
                    exp_q.push_back('{key: k, vis: cyc + 1});
                    mq++;
                end
            end
            if (pop) mq--;
        end
        @(posedge CLK);
        #1;
        if (do_rst) begin
            model_clear();
            RESET_N = 1'b1;
        end else begin
            cyc++;
        end
    endtask

    task automatic scans(input int n, input logic [8:0] press, input int rdy);
        repeat (n * SP) step(press, rdy, 1'b0);
    endtask

    initial begin
        logic [8:0] pr;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_clear();
        chk_en = 1'b1;

        // Free-run pin pattern, no keys
        scans(2, 9'h000, 2);
        // Key 4 held for 10 scans: one event only
        scans(10, 9'b000010000, 1);
        scans(1, 9'h000, 1);
        // Key 0: 2 pressed, 1 released, 3 pressed
        scans(2, 9'b000000001, 1);
        scans(1, 9'h000, 1);
        scans(3, 9'b000000001, 1);
        scans(1, 9'h000, 1);
        // Keys 0 and 6 in the same column
        scans(4, 9'b001000001, 1);
        scans(1, 9'h000, 1);
        // Keys 0,1,2 with consumer stalled: third event dropped
        scans(3, 9'b000000111, 0);
        scans(1, 9'h000, 0);
        scans(2, 9'h000, 1);
        // Queue full of events 0,3 and key 4 mid-debounce, then reset in col1 BLANK
        scans(1, 9'b000001001, 0);
        scans(2, 9'b000011001, 0);
        repeat (CP + DW) step(9'b000010000, 0, 1'b0);
        step(9'b000010000, 0, 1'b1);
        scans(4, 9'b000010000, 1);
        scans(1, 9'h000, 1);
        // Randomized holds, releases, LED patterns and consumer stalls
        pr = '0;
        for (int s = 0; s < 30; s++) begin
            pr = pr ^ 9'($urandom & $urandom & $urandom);
            repeat (SP - 1) step(pr, 2, 1'b0);
            LEDS_IN = 9'($urandom);
            step(pr, 2, 1'b0);
        end
        scans(2, 9'h000, 1);
        check("drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
